// File: rtl/nasti_rw_scheduler.sv
// nasti_rw_scheduler: drains NASTI AR/AW/W FIFOs onto one DDR command port.
// Define NASTI_SCHED_WLAST_CHECK_EN to flag w_last/beat-count mismatches.
module nasti_rw_scheduler #(
  parameter int C_NASTI_ID_WIDTH   = 4,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_MAX_PENDING      = 5,
  parameter int C_BATCH            = 4,
  localparam int IW = C_NASTI_ID_WIDTH,
  localparam int AW = C_NASTI_ADDR_WIDTH,
  localparam int XW = IW + AW + 8,
  localparam int WW = C_NASTI_DATA_WIDTH
                    + C_NASTI_DATA_WIDTH / 8 + 1
) (
  input  logic          core_clk,
  input  logic          core_arstn,
  input  logic [XW-1:0] ar_rdata,
  input  logic          ar_rempty,
  output logic          ar_rinc,
  input  logic [XW-1:0] aw_rdata,
  input  logic          aw_rempty,
  output logic          aw_rinc,
  input  logic [WW-1:0] w_rdata,
  input  logic          w_rempty,
  output logic          w_rinc,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_write,
  output logic [IW-1:0] cmd_id,
  output logic [AW-1:0] cmd_addr,
  output logic [7:0]    cmd_len,
  output logic          wd_valid,
  input  logic          wd_ready,
  input  logic          rd_done,
  output logic          wlast_err
);

  localparam int PW = $clog2(C_MAX_PENDING + 1);
  localparam int SW = $clog2(C_BATCH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_CMD,
    WR_CMD,
    WR_DATA
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          run;
  logic [PW-1:0] pend;
  logic [SW-1:0] streak;
  logic          last_dir;
  logic [7:0]    beat;

  logic          rd_ok;
  logic          wr_ok;
  logic          batch_full;
  logic          pick_wr;
  logic          in_idle;
  logic          gnt_rd;
  logic          gnt_wr;
  logic          rd_issue;
  logic          wr_issue;
  logic          last_beat;
  logic [XW-1:0] gnt_trans;
  logic          w_unused;

  // last_dir: 0 = read, 1 = write.
  assign rd_ok = ~ar_rempty
               & (pend < PW'(C_MAX_PENDING));
  assign wr_ok = ~aw_rempty & ~w_rempty;

  assign batch_full = (streak >= SW'(C_BATCH));
  assign pick_wr    = batch_full ^ last_dir;

  assign in_idle = run & (state == IDLE);
  assign gnt_rd  = in_idle & rd_ok
                 & (~wr_ok | ~pick_wr);
  assign gnt_wr  = in_idle & wr_ok
                 & (~rd_ok | pick_wr);

  assign gnt_trans = gnt_wr ? aw_rdata
                            : ar_rdata;

  assign rd_issue  = (state == RD_CMD) & cmd_ready;
  assign wr_issue  = (state == WR_CMD) & cmd_ready;
  assign last_beat = (beat == cmd_len);

  // Payload bits flow to the DDR side outside this block.
  assign w_unused = ^w_rdata;

  // State register.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) state <= IDLE;
    else             state <= state_nxt;
  end

  // Hold off grants for one cycle after reset release.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) run <= 1'b0;
    else             run <= 1'b1;
  end

  // Next state, pop strobes and handshake outputs.
  always_comb begin
    state_nxt = state;
    ar_rinc   = 1'b0;
    aw_rinc   = 1'b0;
    w_rinc    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    wd_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          gnt_rd: begin
            ar_rinc   = 1'b1;
            state_nxt = RD_CMD;
          end
          gnt_wr: begin
            aw_rinc   = 1'b1;
            state_nxt = WR_CMD;
          end
          default: ;
        endcase
      end
      RD_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_nxt = IDLE;
      end
      WR_CMD: begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        if (cmd_ready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        wd_valid = ~w_rempty;
        w_rinc   = ~w_rempty & wd_ready;
        if (w_rinc && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted transaction into the command fields.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      {cmd_id, cmd_addr, cmd_len} <= '0;
    end else if (gnt_rd | gnt_wr) begin
      {cmd_id, cmd_addr, cmd_len} <= gnt_trans;
    end
  end

  // Same-direction streak, saturating at the batch size.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      streak   <= '0;
      last_dir <= 1'b0;
    end else if (gnt_rd | gnt_wr) begin
      if (gnt_wr == last_dir) begin
        if (!batch_full) streak <= streak + SW'(1);
      end else begin
        streak   <= SW'(1);
        last_dir <= gnt_wr;
      end
    end
  end

  // Reads in flight; simultaneous issue and return cancel out.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      pend <= '0;
    end else if (rd_issue & ~rd_done) begin
      pend <= pend + PW'(1);
    end else if (~rd_issue & rd_done & (pend != '0)) begin
      pend <= pend - PW'(1);
    end
  end

  // Write beat counter for the current burst.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn)  beat <= '0;
    else if (wr_issue) beat <= '0;
    else if (w_rinc)   beat <= beat + 8'd1;
  end

`ifdef NASTI_SCHED_WLAST_CHECK_EN
  // Sticky flag: w_last must mark exactly the counted final beat.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      wlast_err <= 1'b0;
    end else if (w_rinc && (w_rdata[0] != last_beat)) begin
      wlast_err <= 1'b1;
    end
  end
`else
  assign wlast_err = 1'b0;
`endif

endmodule
